wordle_row_writer: RTL and testbench

Game-side writer for the Wordle tile grid. It accepts key events (letter, backspace, enter) over a valid/ready handshake and tracks the cursor over a ROWS×COLS board. For each board change it issues one tile write of `row`/`col`/`display` toward the VGA tile store. On enter with a full row, it scores the guess against the answer word using Wordle duplicate-letter rules, rewrites the row's five tiles with their colour states, and flags win/loss.

---
 rtl/wordle_pkg.sv | 24 ++
 rtl/wordle_row_writer_if.sv | 18 +
 rtl/wordle_yellow_finder.sv | 22 ++
 rtl/wordle_row_writer.sv | 151 +++++++++++++++
 tb/tb_wordle_row_writer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Shared codes and helpers for the Wordle row writer.
package wordle_pkg;
  localparam int ROWS_DEFAULT = 6;
  localparam int COLS_DEFAULT = 5;

  localparam logic [1:0] TILE_TYPED   = 2'b00;
  localparam logic [1:0] TILE_ABSENT  = 2'b01;
  localparam logic [1:0] TILE_PRESENT = 2'b10;
  localparam logic [1:0] TILE_CORRECT = 2'b11;

  localparam logic [1:0] KEY_LETTER = 2'b00;
  localparam logic [1:0] KEY_BACK   = 2'b01;
  localparam logic [1:0] KEY_ENTER  = 2'b10;
  localparam logic [1:0] KEY_NONE   = 2'b11;

  localparam logic [4:0] BLANK_LETTER = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_SCORE_G, S_SCORE_Y, S_WRITE, S_DONE} fsm_t;

  // Tile code as seen by the VGA tile store: colour state above the letter.
  function automatic logic [6:0] tile_code(input logic [1:0] st, input logic [4:0] letter);
    return {st, letter};
  endfunction
endpackage

// File: rtl/wordle_row_writer_if.sv
// Key-event handshake plus tile-write bus between game logic and tile store.
interface wordle_row_writer_if;
  logic       key_valid;
  logic       key_ready;
  logic [1:0] key_cmd;
  logic [4:0] key_code;
  logic       wr_en;
  logic [2:0] row;
  logic [2:0] col;
  logic [6:0] display;

  // Keyboard / tile-store side.
  modport master (output key_valid, key_cmd, key_code,
                  input  key_ready, wr_en, row, col, display);
  // The row writer itself.
  modport slave  (input  key_valid, key_cmd, key_code,
                  output key_ready, wr_en, row, col, display);
endinterface

// File: rtl/wordle_yellow_finder.sv
// Finds the lowest unused answer position holding a given letter.
module wordle_yellow_finder
  import wordle_pkg::*;
(
  input  logic [4:0]  letter,
  input  logic [24:0] answer,
  input  logic [4:0]  used,
  output logic        found,
  output logic [2:0]  pos
);
  // Scan high to low so the lowest match is the one left standing.
  always_comb begin
    found = 1'b0;
    pos   = 3'd0;
    for (int p = 4; p >= 0; p--) begin
      if (!used[p] && answer[5*p +: 5] == letter) begin
        found = 1'b1;
        pos   = 3'(p);
      end
    end
  end
endmodule

// File: rtl/wordle_row_writer.sv
// Cursor tracking, guess scoring and tile writes for one Wordle board.
module wordle_row_writer
  import wordle_pkg::*;
#(
  parameter int ROWS = ROWS_DEFAULT,
  parameter int COLS = COLS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 clr,
  wordle_row_writer_if.slave   bus,
  input  logic [24:0]          answer,
  output logic                 game_over,
  output logic                 win
);
  fsm_t st, st_n;
  logic [2:0]            idx;
  logic [2:0]            cur_row, cur_col;
  logic [COLS-1:0][4:0]  guess;
  logic [COLS-1:0][4:0]  ans;
  logic [COLS-1:0][1:0]  tile;
  logic [COLS-1:0]       used;
  logic                  ready;
  logic                  accept, full, all_green;
  logic                  y_found;
  logic [2:0]            y_pos;

  assign ans           = answer;
  assign bus.key_ready = ready;
  assign accept        = bus.key_valid & ready;
  assign full          = (cur_col == 3'(COLS));
  assign all_green     = (tile == {COLS{TILE_CORRECT}});

  wordle_yellow_finder u_yellow (
    .letter (guess[idx]),
    .answer (answer),
    .used   (used),
    .found  (y_found),
    .pos    (y_pos)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!clr) st <= S_IDLE;
    else      st <= st_n;
  end

  // Next-state: idle until a full-row enter, then score, write, and settle.
  always_comb begin
    st_n = st;
    case (st)
      S_IDLE:    if (accept && bus.key_cmd == KEY_ENTER && full) st_n = S_SCORE_G;
      S_SCORE_G: st_n = S_SCORE_Y;
      S_SCORE_Y: if (idx == 3'(COLS-1)) st_n = S_WRITE;
      S_WRITE:   if (idx == 3'(COLS-1))
                   st_n = (all_green || cur_row == 3'(ROWS-1)) ? S_DONE : S_IDLE;
      default:   st_n = S_DONE;
    endcase
  end

  // Datapath: cursor, guess buffer, scoring flags and registered tile writes.
  always_ff @(posedge clk) begin
    if (!clr) begin
      ready       <= 1'b0;
      idx         <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      guess       <= '0;
      tile        <= '0;
      used        <= '0;
      bus.wr_en   <= 1'b0;
      bus.row     <= '0;
      bus.col     <= '0;
      bus.display <= '0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      ready     <= (st_n == S_IDLE);
      case (st)
        S_IDLE: if (accept) begin
          case (bus.key_cmd)
            KEY_LETTER: if (!full) begin
              guess[cur_col] <= bus.key_code;
              bus.wr_en      <= 1'b1;
              bus.row        <= cur_row;
              bus.col        <= cur_col;
              bus.display    <= tile_code(TILE_TYPED, bus.key_code);
              cur_col        <= cur_col + 3'd1;
            end
            KEY_BACK: if (cur_col != 3'd0) begin
              cur_col     <= cur_col - 3'd1;
              bus.wr_en   <= 1'b1;
              bus.row     <= cur_row;
              bus.col     <= cur_col - 3'd1;
              bus.display <= tile_code(TILE_TYPED, BLANK_LETTER);
            end
            default: ;
          endcase
        end
        S_SCORE_G: begin
          idx <= '0;
          for (int c = 0; c < COLS; c++) begin
            used[c] <= (guess[c] == ans[c]);
            tile[c] <= (guess[c] == ans[c]) ? TILE_CORRECT : TILE_TYPED;
          end
        end
        S_SCORE_Y: begin
          if (tile[idx] != TILE_CORRECT) begin
            if (y_found) begin
              tile[idx]   <= TILE_PRESENT;
              used[y_pos] <= 1'b1;
            end else begin
              tile[idx] <= TILE_ABSENT;
            end
          end
          if (idx == 3'(COLS-1)) begin
            // Column 0 is already final, so its write is launched now.
            idx         <= '0;
            bus.wr_en   <= 1'b1;
            bus.row     <= cur_row;
            bus.col     <= 3'd0;
            bus.display <= tile_code(tile[0], guess[0]);
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_WRITE: begin
          if (idx != 3'(COLS-1)) begin
            idx         <= idx + 3'd1;
            bus.wr_en   <= 1'b1;
            bus.row     <= cur_row;
            bus.col     <= idx + 3'd1;
            bus.display <= tile_code(tile[idx + 3'd1], guess[idx + 3'd1]);
          end else begin
            idx <= '0;
            if (all_green) begin
              win       <= 1'b1;
              game_over <= 1'b1;
            end else if (cur_row == 3'(ROWS-1)) begin
              game_over <= 1'b1;
            end else begin
              cur_row <= cur_row + 3'd1;
              cur_col <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wordle_row_writer.sv
// Self-checking bench: fixed guess table, boundary sequences, random games.
module tb_wordle_row_writer;
  import wordle_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [24:0] answer = '0;
  logic        game_over, win;
  int          checks = 0;
  int          errors = 0;

  wordle_row_writer_if bus();

  wordle_row_writer #(.ROWS(6), .COLS(5)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .answer    (answer),
    .game_over (game_over),
    .win       (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            g;
    string            a;
    logic [4:0][1:0]  st;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0][4:0] word(input string s);
    logic [4:0][4:0] w;
    for (int i = 0; i < 5; i++) w[i] = 5'(s[i] - 8'd65);
    return w;
  endfunction

  // Reference scoring: greens first, then yellows drawn from the pool of
  // answer letters not consumed by greens, left to right.
  function automatic logic [4:0][1:0] score(input logic [4:0][4:0] g, input logic [4:0][4:0] a);
    logic [4:0][1:0] s;
    int cnt[32];
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    for (int c = 0; c < 5; c++) begin
      if (g[c] == a[c]) s[c] = 2'b11;
      else begin s[c] = 2'b01; cnt[a[c]]++; end
    end
    for (int c = 0; c < 5; c++)
      if (s[c] != 2'b11 && cnt[g[c]] > 0) begin s[c] = 2'b10; cnt[g[c]]--; end
    return s;
  endfunction

  function automatic logic [13:0] wr_vec();
    return {bus.wr_en, bus.row, bus.col, bus.display};
  endfunction

  // Offer one key for one cycle; returns at the negedge after the edge.
  task automatic key(input logic [1:0] cmd, input logic [4:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_cmd   = cmd;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.key_ready, 0);
    chk("rst_wr", wr_vec(), 0);
    chk("rst_flags", {game_over, win}, 0);
    clr = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", bus.key_ready, 1);
  endtask

  task automatic score_row(input logic [4:0][4:0] g, input logic [2:0] r, input logic [4:0][1:0] es);
    logic over, w;
    w    = (es == 10'h3FF);
    over = w || (r == 3'd5);
    key(KEY_ENTER, 5'd0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      chk("busy_ready", bus.key_ready, 0);
      if (cyc >= 7) chk("score_wr", wr_vec(), {1'b1, r, 3'(cyc - 7), es[cyc - 7], g[cyc - 7]});
      else          chk("score_quiet", bus.wr_en, 0);
      @(negedge clk);
    end
    chk("end_ready", bus.key_ready, !over);
    chk("end_game_over", game_over, over);
    chk("end_win", win, w);
  endtask

  task automatic play_row(input logic [4:0][4:0] g, input logic [2:0] r, input logic [4:0][1:0] es);
    for (int c = 0; c < 5; c++) begin
      key(KEY_LETTER, g[c]);
      chk("type_wr", wr_vec(), {1'b1, r, 3'(c), 2'b00, g[c]});
    end
    score_row(g, r, es);
  endtask

  vec_t            tbl[3];
  logic [4:0][4:0] g, a;

  initial begin
    bus.key_valid = 1'b0;
    bus.key_cmd   = '0;
    bus.key_code  = '0;

    tbl[0].g = "EERIE"; tbl[0].a = "CRANE"; tbl[0].st = {2'b11, 2'b01, 2'b10, 2'b01, 2'b01};
    tbl[1].g = "ACRES"; tbl[1].a = "CRANE"; tbl[1].st = {2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    tbl[2].g = "CRANE"; tbl[2].a = "CRANE"; tbl[2].st = 10'h3FF;

    // Fixed guess table: rows 0..2 of one game, ending in a win.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      answer = word(tbl[i].a);
      play_row(word(tbl[i].g), 3'(i), tbl[i].st);
    end
    key(KEY_LETTER, 5'd1);
    chk("done_no_write", bus.wr_en, 0);
    chk("done_ready", bus.key_ready, 0);

    // Boundary keys on a fresh board.
    do_reset();
    answer = word("CRANE");
    key(KEY_BACK, 5'd0);
    chk("bs_col0_no_write", bus.wr_en, 0);
    chk("bs_col0_ready", bus.key_ready, 1);
    for (int c = 0; c < 3; c++) begin
      key(KEY_LETTER, 5'(c));
      chk("bnd_type", wr_vec(), {1'b1, 3'd0, 3'(c), 2'b00, 5'(c)});
    end
    key(KEY_BACK, 5'd0);
    chk("bs_after3", wr_vec(), {1'b1, 3'd0, 3'd2, 2'b00, 5'd31});
    key(KEY_LETTER, 5'd3);
    key(KEY_LETTER, 5'd4);
    key(KEY_ENTER, 5'd0);
    chk("enter4_no_write", bus.wr_en, 0);
    chk("enter4_ready", bus.key_ready, 1);
    key(KEY_LETTER, 5'd5);
    chk("fifth_wr", wr_vec(), {1'b1, 3'd0, 3'd4, 2'b00, 5'd5});
    key(KEY_LETTER, 5'd6);
    chk("sixth_hold", wr_vec(), {1'b0, 3'd0, 3'd4, 2'b00, 5'd5});
    key(KEY_NONE, 5'd7);
    chk("cmd11_hold", wr_vec(), {1'b0, 3'd0, 3'd4, 2'b00, 5'd5});
    g = word("ABDEF");
    score_row(g, 3'd0, score(g, word("CRANE")));

    // Reset in the middle of the tile write-back.
    do_reset();
    answer = word("CRANE");
    g = word("TOUCH");
    play_row(g, 3'd0, score(g, answer));
    g = word("NACRE");
    for (int c = 0; c < 5; c++) key(KEY_LETTER, g[c]);
    key(KEY_ENTER, 5'd0);
    repeat (8) @(negedge clk);
    chk("mid_write_active", wr_vec(), {1'b1, 3'd1, 3'd2, score(g, answer)[2], g[2]});
    clr = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr", wr_vec(), 0);
    chk("mid_rst_ready", bus.key_ready, 0);
    chk("mid_rst_flags", {game_over, win}, 0);
    clr = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", bus.key_ready, 1);
    key(KEY_LETTER, 5'd9);
    chk("mid_rst_cursor", wr_vec(), {1'b1, 3'd0, 3'd0, 2'b00, 5'd9});

    // Random games against the reference model; the last one is forced to lose.
    for (int game = 0; game < 4; game++) begin
      do_reset();
      for (int c = 0; c < 5; c++) a[c] = 5'($urandom_range(25));
      answer = a;
      for (int r = 0; r < 6; r++) begin
        logic [4:0][1:0] es;
        for (int c = 0; c < 5; c++)
          g[c] = ($urandom_range(1) == 1) ? a[$urandom_range(4)] : 5'($urandom_range(25));
        if (game == 3 || r == 0) begin
          if (g == a) g[0] = 5'((int'(g[0]) + 1) % 26);
        end else if ($urandom_range(9) == 0) begin
          g = a;
        end
        es = score(g, a);
        play_row(g, 3'(r), es);
        if (es == 10'h3FF) break;
      end
      chk("game_ended", game_over, 1);
    end
    chk("loss_win", win, 0);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_cmd   = KEY_LETTER;
    bus.key_code  = 5'd2;
    repeat (3) begin
      @(negedge clk);
      chk("loss_refuse_ready", bus.key_ready, 0);
      chk("loss_refuse_wr", bus.wr_en, 0);
    end
    bus.key_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
